// File: rtl/dff_bank_sched.sv
// Round-robin scheduler that sequences LOAD/CLEAR/PRESET/READ operations onto a
// shared D_FF bank, reads the bank back and reports a one-cycle checked response.
//
//   state  | meaning
//   IDLE   | waiting for a request; ready goes to the granted requester
//   APPLY  | bank controls driven for exactly one cycle
//   SETTLE | controls released, bank output settles
//   CHECK  | bank_q sampled and compared with the expected value
//   RESP   | rsp_valid strobe with id/data/err
module dff_bank_sched #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic [W-1:0]     bank_d,
    output logic             bank_clear_n,
    output logic             bank_preset_n,
    output logic             bank_enable,
    input  logic [W-1:0]     bank_q,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] APPLY  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    logic [2:0]   state;
    logic         last_grant;
    logic [1:0]   op_r;
    logic [W-1:0] data_r;
    logic         id_r;

    logic         grant_any;
    logic         grant_id;
    logic         handshake;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_data;
    logic [W-1:0] exp_q;
    logic         mismatch;

    // When both requesters are valid the one that did not win last time is served.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
        req0_ready = (state == IDLE) && grant_any && !grant_id;
        req1_ready = (state == IDLE) && grant_any && grant_id;
        handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_op     = grant_id ? req1_op : req0_op;
        sel_data   = grant_id ? req1_data : req0_data;
    end

    always_comb begin
        exp_q = '0;
        case (op_r)
            OP_LOAD:   exp_q = data_r;
            OP_CLEAR:  exp_q = '0;
            OP_PRESET: exp_q = '1;
            default:   exp_q = '0;
        endcase
        mismatch = (op_r != OP_READ) && (bank_q != exp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_r          <= OP_LOAD;
            data_r        <= '0;
            id_r          <= 1'b0;
            bank_d        <= '0;
            bank_clear_n  <= 1'b1;
            bank_preset_n <= 1'b1;
            bank_enable   <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            err_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state         <= APPLY;
                        last_grant    <= grant_id;
                        op_r          <= sel_op;
                        data_r        <= sel_data;
                        id_r          <= grant_id;
                        // Controls are registered here so they appear exactly in APPLY.
                        bank_enable   <= (sel_op != OP_READ);
                        bank_clear_n  <= (sel_op != OP_CLEAR);
                        bank_preset_n <= (sel_op != OP_PRESET);
                        if (sel_op == OP_LOAD) begin
                            bank_d <= sel_data;
                        end
                    end
                end
                APPLY: begin
                    state         <= SETTLE;
                    bank_enable   <= 1'b0;
                    bank_clear_n  <= 1'b1;
                    bank_preset_n <= 1'b1;
                end
                SETTLE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_r;
                    rsp_data  <= bank_q;
                    rsp_err   <= mismatch;
                    if (mismatch && (err_count != '1)) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_sched.sv
// Bench for dff_bank_sched: behavioural D_FF bank, scoreboard of expected
// responses filled at handshake and drained when rsp_valid fires.
module tb_dff_bank_sched;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [1:0]       req0_op = 2'b00;
    logic [W-1:0]     req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [1:0]       req1_op = 2'b00;
    logic [W-1:0]     req1_data = '0;
    logic             req1_ready;
    logic [W-1:0]     bank_d;
    logic             bank_clear_n;
    logic             bank_preset_n;
    logic             bank_enable;
    logic [W-1:0]     bank_q;
    logic             rsp_valid;
    logic             rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic [CNT_W-1:0] err_count;

    dff_bank_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
        .bank_d(bank_d), .bank_clear_n(bank_clear_n), .bank_preset_n(bank_preset_n),
        .bank_enable(bank_enable), .bank_q(bank_q),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural bank; corrupt forces the readback to 5 to provoke mismatches.
    logic [W-1:0] bank_reg = '0;
    logic         corrupt = 1'b0;
    always @(posedge clk) begin
        if (!bank_clear_n)       bank_reg <= '0;
        else if (!bank_preset_n) bank_reg <= '1;
        else if (bank_enable)    bank_reg <= bank_d;
    end
    assign bank_q = corrupt ? 4'h5 : bank_reg;

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic       err;
        int         hs;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_hs = -100;
    logic [1:0] last_op = 2'b00;
    logic [3:0] last_data = 4'h0;
    logic [3:0] shadow = 4'h0;
    int   model_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard push on handshake, control-timing and response checks.
    exp_t       m_e;
    logic [1:0] m_op;
    logic [3:0] m_data, m_ev, m_rd;
    logic       m_id, m_apply, m_en, m_cn, m_pn;
    always @(negedge clk) begin
        if (rst) begin
            model_cnt = 0;
        end else begin
            checks++;
            if (req0_ready && req1_ready) begin
                failures++;
                $display("FAIL one_ready: req0_ready=%b req1_ready=%b required at most one", req0_ready, req1_ready);
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                m_id   = req1_ready;
                m_op   = m_id ? req1_op : req0_op;
                m_data = m_id ? req1_data : req0_data;
                case (m_op)
                    2'd0:    m_ev = m_data;
                    2'd1:    m_ev = 4'h0;
                    2'd2:    m_ev = 4'hF;
                    default: m_ev = shadow;
                endcase
                shadow  = m_ev;
                m_rd    = corrupt ? 4'h5 : m_ev;
                m_e.id  = m_id;
                m_e.data = m_rd;
                m_e.err = (m_op != 2'd3) && (m_rd != m_ev);
                m_e.hs  = cyc;
                sb.push_back(m_e);
                grants.push_back(int'(m_id));
                last_hs   = cyc;
                last_op   = m_op;
                last_data = m_data;
            end
            m_apply = (cyc == last_hs + 1);
            m_en = m_apply && (last_op != 2'd3);
            m_cn = !(m_apply && (last_op == 2'd1));
            m_pn = !(m_apply && (last_op == 2'd2));
            checks++;
            if ({bank_enable, bank_clear_n, bank_preset_n} !== {m_en, m_cn, m_pn}) begin
                failures++;
                $display("FAIL bank_ctrl cyc=%0d: en/clr_n/pre_n=%b%b%b required %b%b%b",
                         cyc, bank_enable, bank_clear_n, bank_preset_n, m_en, m_cn, m_pn);
            end
            checks++;
            if (!bank_clear_n && !bank_preset_n) begin
                failures++;
                $display("FAIL clr_pre_both_low cyc=%0d: clear_n=0 preset_n=0 required not both low", cyc);
            end
            if (m_apply && last_op == 2'd0) begin
                checks++;
                if (bank_d !== last_data) begin
                    failures++;
                    $display("FAIL bank_d cyc=%0d: got %h required %h", cyc, bank_d, last_data);
                end
            end
            if (rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp cyc=%0d: rsp_valid=1 required 0 (nothing pending)", cyc);
                end else begin
                    m_e = sb.pop_front();
                    if ({rsp_id, rsp_data, rsp_err} !== {m_e.id, m_e.data, m_e.err} || cyc != m_e.hs + 4) begin
                        failures++;
                        $display("FAIL rsp cyc=%0d: id=%b data=%h err=%b lat=%0d required id=%b data=%h err=%b lat=4",
                                 cyc, rsp_id, rsp_data, rsp_err, cyc - m_e.hs, m_e.id, m_e.data, m_e.err);
                    end
                    if (m_e.err && model_cnt < 255) model_cnt++;
                    checks++;
                    if (err_count !== 8'(model_cnt)) begin
                        failures++;
                        $display("FAIL err_count cyc=%0d: got %0d required %0d", cyc, err_count, model_cnt);
                    end
                end
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [3:0] data);
        int   n;
        logic rdy;
        n = 0;
        @(posedge clk);
        #1;
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_data = data; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_data = data; end
        do begin
            @(negedge clk);
            n++;
            rdy = id ? req1_ready : req0_ready;
        end while (!rdy && n < 20);
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL ready_timeout id=%0d: ready=0 after %0d cycles required 1", id, n);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rsp_timeout: pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++;
        if ({bank_d, bank_clear_n, bank_preset_n, bank_enable, req0_ready, req1_ready} !== {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_bank: d=%h clr_n=%b pre_n=%b en=%b rdy=%b%b required 0 1 1 0 00",
                     bank_d, bank_clear_n, bank_preset_n, bank_enable, req0_ready, req1_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err, err_count} !== {1'b0, 1'b0, 4'h0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_rsp: v=%b id=%b data=%h err=%b cnt=%h required all zero",
                     rsp_valid, rsp_id, rsp_data, rsp_err, err_count);
        end
    endtask

    task automatic test_load;
        issue(1'b0, 2'd0, 4'hA);
        drain();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 4'hA) begin
            failures++;
            $display("FAIL load_hold: valid=%b data=%h required 0 A", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_arbitration;
        int n;
        do_reset();
        grants.delete();
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 2'd0; req0_data = 4'h1;
        req1_valid = 1'b1; req1_op = 2'd0; req1_data = 4'h2;
        n = 0;
        while (grants.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= grants.size()) begin
                failures++;
                $display("FAIL arb_grant%0d: missing required %0d", i, i % 2);
            end else if (grants[i] != i % 2) begin
                failures++;
                $display("FAIL arb_grant%0d: got %0d required %0d", i, grants[i], i % 2);
            end
        end
        drain();
    endtask

    task automatic test_clear_preset;
        issue(1'b1, 2'd1, 4'h7);
        drain();
        checks++;
        if (rsp_data !== 4'h0 || rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL clear_rsp: data=%h id=%b required 0 1", rsp_data, rsp_id);
        end
        issue(1'b0, 2'd2, 4'h0);
        drain();
        checks++;
        if (rsp_data !== 4'hF || rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL preset_rsp: data=%h id=%b required F 0", rsp_data, rsp_id);
        end
    endtask

    task automatic test_mismatch;
        corrupt = 1'b1;
        issue(1'b0, 2'd0, 4'h3);
        drain();
        checks++;
        if (rsp_err !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL mismatch_first: err=%b cnt=%0d required 1 1", rsp_err, err_count);
        end
        for (int i = 0; i < 254; i++) begin
            issue(1'b0, 2'd0, 4'h3);
            drain();
        end
        checks++;
        if (err_count !== 8'hFF) begin
            failures++;
            $display("FAIL mismatch_255: cnt=%h required FF", err_count);
        end
        issue(1'b1, 2'd0, 4'h3);
        drain();
        checks++;
        if (err_count !== 8'hFF || rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_sat: cnt=%h err=%b required FF 1", err_count, rsp_err);
        end
        corrupt = 1'b0;
    endtask

    task automatic test_rst_mid;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 2'd0; req0_data = 4'h9;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_hs: ready=%b required 1", req0_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({bank_d, bank_clear_n, bank_preset_n, bank_enable, rsp_valid, rsp_data, err_count}
            !== {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00}) begin
            failures++;
            $display("FAIL rst_mid_state: d=%h clr_n=%b pre_n=%b en=%b v=%b data=%h cnt=%h required 0 1 1 0 0 0 00",
                     bank_d, bank_clear_n, bank_preset_n, bank_enable, rsp_valid, rsp_data, err_count);
        end
        repeat (4) @(negedge clk);
        issue(1'b0, 2'd3, 4'h0);
        drain();
    endtask

    task automatic test_read;
        issue(1'b0, 2'd0, 4'h6);
        drain();
        issue(1'b1, 2'd3, 4'hC);
        drain();
        checks++;
        if (rsp_data !== 4'h6 || rsp_err !== 1'b0 || rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL read_rsp: data=%h err=%b id=%b required 6 0 1", rsp_data, rsp_err, rsp_id);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_arbitration();
        test_clear_preset();
        test_mismatch();
        test_rst_mid();
        test_read();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t required finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
